// File: rtl/alu_pipe.sv
// Two-stage pipelined Mic-1 style ALU with an output shifter, N/Z/C/V flags,
// a sticky overflow flag and valid/ready handshakes on both sides.
module alu_pipe #(
    parameter int unsigned N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         F0,
    input  logic         F1,
    input  logic         ENA,
    input  logic         ENB,
    input  logic         INVA,
    input  logic         INC,
    input  logic         SLL8,
    input  logic         SRA1,
    input  logic         ovclr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] FUNC,
    output logic         Nflag,
    output logic         Zflag,
    output logic         Carry,
    output logic         Ovflag,
    output logic         Ovsticky
);

    localparam int unsigned SW = N + 1;

    logic         s1_valid_q, s1_valid_d;
    logic [N-1:0] s1_res_q,   s1_res_d;
    logic         s1_carry_q, s1_carry_d;
    logic         s1_ov_q,    s1_ov_d;
    logic         s1_sll8_q,  s1_sll8_d;
    logic         s1_sra1_q,  s1_sra1_d;

    logic         s2_valid_q, s2_valid_d;
    logic [N-1:0] func_q,     func_d;
    logic         nflag_q,    nflag_d;
    logic         zflag_q,    zflag_d;
    logic         carry_q,    carry_d;
    logic         ovflag_q,   ovflag_d;
    logic         ovsticky_q, ovsticky_d;

    logic [N-1:0]  a_g, b_g, alu_res, shifted;
    logic [SW-1:0] sum;
    logic          alu_c, alu_ov, s1_move, s1_open;

    // Stage 1 can hand its op on whenever stage 2 is empty or draining.
    assign s1_move  = !s2_valid_q || out_ready;
    assign s1_open  = !s1_valid_q || s1_move;
    assign in_ready = !rst && s1_open;

    // Operand gating and function unit.
    always_comb begin
        a_g     = (ENA ? A : '0) ^ {N{INVA}};
        b_g     = ENB ? B : '0;
        sum     = {1'b0, a_g} + {1'b0, b_g} + SW'(INC);
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ov  = 1'b0;
        case ({F0, F1})
            2'b00: alu_res = a_g & b_g;
            2'b01: alu_res = a_g | b_g;
            2'b10: alu_res = ~b_g;
            default: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_ov  = (a_g[N-1] == b_g[N-1]) && (sum[N-1] != a_g[N-1]);
            end
        endcase
    end

    // Output shifter; SLL8 has priority over SRA1.
    always_comb begin
        shifted = s1_res_q;
        if (s1_sll8_q) begin
            shifted = {s1_res_q[N-9:0], 8'b0};
        end else if (s1_sra1_q) begin
            shifted = {s1_res_q[N-1], s1_res_q[N-1:1]};
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_res_d   = s1_res_q;
        s1_carry_d = s1_carry_q;
        s1_ov_d    = s1_ov_q;
        s1_sll8_d  = s1_sll8_q;
        s1_sra1_d  = s1_sra1_q;
        s2_valid_d = s2_valid_q;
        func_d     = func_q;
        nflag_d    = nflag_q;
        zflag_d    = zflag_q;
        carry_d    = carry_q;
        ovflag_d   = ovflag_q;
        ovsticky_d = ovsticky_q;

        if (s1_open) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_res_d   = alu_res;
                s1_carry_d = alu_c;
                s1_ov_d    = alu_ov;
                s1_sll8_d  = SLL8;
                s1_sra1_d  = SRA1;
            end
        end

        // Output registers only change when a new op enters stage 2.
        if (s1_move) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                func_d   = shifted;
                nflag_d  = shifted[N-1];
                zflag_d  = (shifted == '0);
                carry_d  = s1_carry_q;
                ovflag_d = s1_ov_q;
            end
        end

        if (ovclr) begin
            ovsticky_d = 1'b0;
        end
        if (s2_valid_q && out_ready && ovflag_q) begin
            ovsticky_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_carry_q <= 1'b0;
            s1_ov_q    <= 1'b0;
            s1_sll8_q  <= 1'b0;
            s1_sra1_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            func_q     <= '0;
            nflag_q    <= 1'b0;
            zflag_q    <= 1'b0;
            carry_q    <= 1'b0;
            ovflag_q   <= 1'b0;
            ovsticky_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_res_q   <= s1_res_d;
            s1_carry_q <= s1_carry_d;
            s1_ov_q    <= s1_ov_d;
            s1_sll8_q  <= s1_sll8_d;
            s1_sra1_q  <= s1_sra1_d;
            s2_valid_q <= s2_valid_d;
            func_q     <= func_d;
            nflag_q    <= nflag_d;
            zflag_q    <= zflag_d;
            carry_q    <= carry_d;
            ovflag_q   <= ovflag_d;
            ovsticky_q <= ovsticky_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign FUNC      = func_q;
    assign Nflag     = nflag_q;
    assign Zflag     = zflag_q;
    assign Carry     = carry_q;
    assign Ovflag    = ovflag_q;
    assign Ovsticky  = ovsticky_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed ops push hand-computed results,
// a negedge monitor pops and compares on every delivered result.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [15:0] A, B, FUNC;
    logic        F0, F1, ENA, ENB, INVA, INC, SLL8, SRA1, ovclr;
    logic        out_valid, out_ready;
    logic        Nflag, Zflag, Carry, Ovflag, Ovsticky;

    typedef struct {
        logic [15:0] func;
        logic        n, z, c, ov;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_pipe #(.N(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .F0(F0), .F1(F1), .ENA(ENA), .ENB(ENB), .INVA(INVA),
        .INC(INC), .SLL8(SLL8), .SRA1(SRA1), .ovclr(ovclr),
        .out_valid(out_valid), .out_ready(out_ready), .FUNC(FUNC),
        .Nflag(Nflag), .Zflag(Zflag), .Carry(Carry), .Ovflag(Ovflag),
        .Ovsticky(Ovsticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every delivered result must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(FUNC), 32'hDEAD_BEEF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("func",   32'(FUNC),   32'(e.func));
                check("nflag",  32'(Nflag),  32'(e.n));
                check("zflag",  32'(Zflag),  32'(e.z));
                check("carry",  32'(Carry),  32'(e.c));
                check("ovflag", 32'(Ovflag), 32'(e.ov));
            end
        end
    end

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f,
                         input logic ena, input logic enb, input logic inva, input logic inc,
                         input logic sll8, input logic sra1,
                         input logic [15:0] ef, input logic en, input logic ez,
                         input logic ec, input logic eov);
        logic got;
        exp_t e;
        A = a; B = b; F0 = f[1]; F1 = f[0];
        ENA = ena; ENB = enb; INVA = inva; INC = inc; SLL8 = sll8; SRA1 = sra1;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (got) begin
            e.func = ef; e.n = en; e.z = ez; e.c = ec; e.ov = eov;
            sb.push_back(e);
        end else begin
            check("issue_timeout", 32'(got), 32'd1);
        end
    endtask

    task automatic add(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ef,
                       input logic en, input logic eov);
        issue(a, b, 2'b11, 1, 1, 0, 0, 0, 0, ef, en, 1'b0, 1'b0, eov);
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_func"},      32'(FUNC),      32'd0);
        check({tag, "_flags"},     32'({Nflag, Zflag, Carry, Ovflag, Ovsticky}), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; F0 = 0; F1 = 0;
        ENA = 0; ENB = 0; INVA = 0; INC = 0; SLL8 = 0; SRA1 = 0;
        ovclr = 1'b0; out_ready = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready_low", 32'(in_ready), 32'd0);
        check_cleared("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Basic add and B-A subtract
        add(16'd1, 16'd1, 16'h0002, 0, 0);
        issue(16'd5, 16'd3, 2'b11, 1, 1, 1, 1, 0, 0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // Shifter and ~B zero
        issue(16'h8001, 16'h8001, 2'b01, 0, 1, 0, 0, 0, 1, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0);
        issue(16'h8001, 16'h8001, 2'b01, 0, 1, 0, 0, 1, 0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(16'h8001, 16'h8001, 2'b01, 0, 1, 0, 0, 1, 1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0);
        issue(16'h1234, 16'hFFFF, 2'b10, 1, 1, 0, 0, 0, 0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
        // FFFF + 1 carries out without signed overflow
        add(16'hFFFF, 16'h0001, 16'h0000, 0, 0);
        sb[$].z = 1'b1; sb[$].c = 1'b1;
        drain();
        check("sticky_idle", 32'(Ovsticky), 32'd0);

        // Overflow sets the sticky flag, which holds until ovclr
        add(16'h7FFF, 16'h0001, 16'h8000, 1, 1);
        drain();
        check("sticky_set", 32'(Ovsticky), 32'd1);
        add(16'd1, 16'd1, 16'h0002, 0, 0);
        drain();
        check("sticky_hold", 32'(Ovsticky), 32'd1);
        ovclr = 1'b1;
        @(posedge clk); #1;
        ovclr = 1'b0;
        check("sticky_clear", 32'(Ovsticky), 32'd0);

        // ovclr in the same cycle as an overflowing delivery: set wins
        out_ready = 1'b0;
        add(16'h7FFF, 16'h7FFF, 16'hFFFE, 1, 1);
        repeat (2) @(posedge clk);
        #1;
        check("sticky_not_yet", 32'(Ovsticky), 32'd0);
        ovclr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        ovclr = 1'b0;
        check("sticky_set_wins", 32'(Ovsticky), 32'd1);
        check("sticky_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: two ops fill the pipe, third is held off
        out_ready = 1'b0;
        add(16'd1, 16'd1, 16'd2, 0, 0);
        add(16'd2, 16'd2, 16'd4, 0, 0);
        A = 16'd3; B = 16'd3; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_func_hold", 32'(FUNC), 32'd2);
            @(posedge clk); #1;
        end
        fork
            begin
                out_ready = 1'b1;
                add(16'd3, 16'd3, 16'd6, 0, 0);
                add(16'd4, 16'd4, 16'd8, 0, 0);
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("bp_no_gap", 32'(out_valid), 32'd1);
                end
            end
        join
        drain();

        // Reset with two ops in flight flushes everything
        out_ready = 1'b0;
        add(16'h7FFF, 16'd1, 16'h8000, 1, 1);
        add(16'd9, 16'd9, 16'd18, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        check_cleared("midrst");
        check("midrst_in_ready_release", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        add(16'd20, 16'd22, 16'd42, 0, 0);
        drain();
        check("post_rst_sticky", 32'(Ovsticky), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
